// File: rtl/i2c_target_pkg.sv
// Shared types and bus constants for the I2C register-file target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_IGNORE,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK
  } state_t;

  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;
  localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_bus_sampler.sv
// SCL/SDA synchronizer, optional stability filter (I2C_TARGET_FILTER_EN),
// and SCL edge plus START/STOP detection.
module i2c_bus_sampler #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Index 0 is SCL, index 1 is SDA; idle bus is high so everything resets to 1.
  logic [1:0]      w_raw, w_lvl;
  logic [1:0][1:0] r_sync;
  logic [1:0]      r_prev;

  assign w_raw = {sda_i, scl_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      for (int i = 0; i < 2; i++) r_sync[i] <= {r_sync[i][0], w_raw[i]};
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  for (genvar g = 0; g < 2; g++) begin : g_filt
    logic          r_lvl;
    logic [CW-1:0] r_cnt;
    // Level follows the input only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lvl <= 1'b1;
        r_cnt <= '0;
      end else if (r_sync[g][1] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_lvl <= r_sync[g][1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_lvl[g] = r_lvl;
  end
`else
  // FILT_LEN has no effect without the filter.
  if (FILT_LEN >= 0) begin : g_nofilt
    assign w_lvl = {r_sync[1][1], r_sync[0][1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= '1;
    else        r_prev <= w_lvl;
  end

  assign scl_rise  =  w_lvl[0] & ~r_prev[0];
  assign scl_fall  = ~w_lvl[0] &  r_prev[0];
  assign start_det =  w_lvl[0] &  r_prev[0] &  r_prev[1] & ~w_lvl[1];
  assign stop_det  =  w_lvl[0] &  r_prev[0] & ~r_prev[1] &  w_lvl[1];
  assign sda_s     =  w_lvl[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte register file, pointer auto-increment and host write port.
// Define I2C_TARGET_FILTER_EN to add the SCL/SDA glitch filter in the sampler.
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter  logic [6:0] DEV_ADDR = 7'h2A,
  parameter  int         NUM_REGS = 16,
  parameter  int         FILT_LEN = 3,
  localparam int         PTR_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [7:0]            wr_data,
  input  logic                  hw_we,
  input  logic [PTR_W-1:0]      hw_addr,
  input  logic [7:0]            hw_wdata,
  output logic                  busy
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_bus_sampler #(.FILT_LEN(FILT_LEN)) u_sampler (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda)
  );

  state_t                     r_state;
  logic [7:0]                 r_shift;
  logic [2:0]                 r_bitcnt;
  logic                       r_byte_done, r_mack, r_sda_oe, r_busy, r_wr_strobe;
  logic [PTR_W-1:0]           r_ptr, r_wr_addr;
  logic [7:0]                 r_wr_data;
  logic [NUM_REGS-1:0][7:0]   r_regs;

  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_ptr_inc;
  logic             w_addr_hit, w_hw_ok, w_rx;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_inc  = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
  // r_shift still holds the address byte throughout ADDR_ACK.
  assign w_addr_hit = (r_shift[7:1] == DEV_ADDR) && (r_shift[7:1] != 7'd0) && enable;
  assign w_hw_ok    = hw_we && (32'(hw_addr) < NUM_REGS);
  assign w_rx       = (r_state == ST_ADDR) || (r_state == ST_PTR) || (r_state == ST_WDATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_byte_done <= 1'b0;
      r_mack      <= NACK;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_ptr       <= '0;
      r_regs      <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      // Host write first so a same-cycle I2C write to the same register wins.
      if (w_hw_ok) r_regs[hw_addr] <= hw_wdata;

      if (w_stop)                       r_busy <= 1'b0;
      else if (r_state == ST_ADDR_ACK)  r_busy <= 1'b1;

      if (!enable) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
      end else if (w_start) begin
        r_state     <= ST_ADDR;
        r_bitcnt    <= '0;
        r_byte_done <= 1'b0;
        r_sda_oe    <= 1'b0;
      end else begin
        if (w_scl_rise && w_rx) begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) begin
            r_byte_done <= 1'b1;
            if (r_state == ST_PTR) r_ptr <= PTR_W'(32'(w_byte) % NUM_REGS);
            if (r_state == ST_WDATA) begin
              r_regs[r_ptr] <= w_byte;
              r_wr_strobe   <= 1'b1;
              r_wr_addr     <= r_ptr;
              r_wr_data     <= w_byte;
              r_ptr         <= w_ptr_inc;
            end
          end
        end

        if (w_scl_rise && r_state == ST_RDATA) begin
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) r_byte_done <= 1'b1;
        end

        if (w_scl_rise && r_state == ST_RD_MACK) r_mack <= w_sda;

        if (w_scl_fall) begin
          case (r_state)
            ST_ADDR: if (r_byte_done) begin
              r_byte_done <= 1'b0;
              if (w_addr_hit) begin
                r_state  <= ST_ADDR_ACK;
                r_sda_oe <= ~ACK;
              end else begin
                r_state  <= ST_IGNORE;
              end
            end
            ST_PTR: if (r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_PTR_ACK;
              r_sda_oe    <= ~ACK;
            end
            ST_WDATA: if (r_byte_done) begin
              r_byte_done <= 1'b0;
              r_state     <= ST_WDATA_ACK;
              r_sda_oe    <= ~ACK;
            end
            ST_PTR_ACK, ST_WDATA_ACK: begin
              r_state  <= ST_WDATA;
              r_sda_oe <= 1'b0;
            end
            ST_ADDR_ACK: begin
              if (r_shift[RW_BIT]) begin
                r_shift  <= r_regs[r_ptr];
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_ptr    <= w_ptr_inc;
                r_state  <= ST_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_PTR;
              end
            end
            ST_RDATA: begin
              if (r_byte_done) begin
                r_byte_done <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_state     <= ST_RD_MACK;
              end else begin
                r_sda_oe <= ~r_shift[6];
                r_shift  <= {r_shift[6:0], 1'b0};
              end
            end
            ST_RD_MACK: begin
              if (r_mack == ACK) begin
                r_shift  <= r_regs[r_ptr];
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_ptr    <= w_ptr_inc;
                r_state  <= ST_RDATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_IGNORE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign regs_flat = r_regs;

endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Parametrised I2C target (slave) with an internal byte register file, replacing the fixed-address, single-stream AXI front end on the chip I/O pins. An external controller addresses the block at a configurable 7-bit address, sets a register pointer, then burst-writes or burst-reads registers with pointer auto-increment and wrap. On-chip logic sees every register in parallel, gets a strobe per I2C write, and can update registers through a host write port.

## Interface
- `DEV_ADDR`, 7'h2A: 7-bit target address.
- `NUM_REGS`, 16: number of 8-bit registers, 2..256. `PTR_W = max(1, $clog2(NUM_REGS))` is derived.
- `FILT_LEN`, 3: glitch-filter length in clk cycles; used only with the filter macro.
- `clk  in  1`: system clock, at least 10× the SCL rate.
- `rst_n  in  1`: asynchronous active-low reset.
- `enable  in  1`: when 0, the block ignores the bus and never drives SDA.
- `scl_i  in  1`, `sda_i  in  1`: raw pad inputs.
- `sda_oe  out  1`: 1 pulls SDA low; the pad output is tied to 0. SCL is never driven, so there is no clock stretching.
- `regs_flat  out  8*NUM_REGS`: register i occupies `[8i+7:8i]`.
- `wr_strobe  out  1`, `wr_addr  out  PTR_W`, `wr_data  out  8`: one-cycle pulse per I2C data-byte write.
- `hw_we  in  1`, `hw_addr  in  PTR_W`, `hw_wdata  in  8`: host register write.
- `busy  out  1`: high from an address-matched START until STOP.

## Operation
- Inputs pass through a 2-flop synchronizer, then the optional filter, then an edge detector.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. A repeated START is legal in any state.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first on SCL rising edges.
  - ADDR_ACK: entered on a match with `enable=1`; drive ACK. On a mismatch, go to IGNORE (never drive SDA) until START or STOP.
  - If R/W=0: PTR, then PTR_ACK, then repeated WDATA and WDATA_ACK pairs.
  - If R/W=1: RDATA, then RD_MACK, repeating.
- Write transfer:
  - The first data byte loads `ptr`. The value is taken modulo NUM_REGS; when NUM_REGS is not a power of two, values ≥ NUM_REGS wrap to `ptr = value % NUM_REGS`.
  - Each later byte writes `regs[ptr]`, pulses `wr_strobe` with the address and data, and increments `ptr`.
  - Increment wraps from NUM_REGS-1 to 0.
  - The target ACKs every byte.
- Read transfer:
  - `regs[ptr]` is snapshotted into the shift register at ADDR_ACK or RD_MACK completion, then `ptr` increments.
  - Master ACK continues the burst. Master NACK goes to IGNORE until STOP or START.
- `ptr` persists across transactions. Only reset clears it.
- Host write and I2C write in the same cycle:
  - Different registers: both take effect.
  - Same register: the I2C write wins and `hw_we` is dropped.
- A host write during a read byte does not alter the bits already snapshotted.
- STOP in any state returns to IDLE and releases SDA.
- General call (address 0) is not supported and is NACKed.

## Timing
- Reset values: `sda_oe=0`, `busy=0`, `wr_strobe=0`, `wr_addr=0`, `wr_data=0`, `ptr=0`, all registers 8'h00, state IDLE.
- Asserting reset mid-transfer releases SDA asynchronously.
- Input latency: 2 clk for the synchronizer, plus FILT_LEN clk with the filter.
- `sda_oe` changes only in the cycle after a detected SCL falling edge, so SDA hold is at least 1 clk after SCL low. It is never changed while SCL is high.
- ACK drive runs from the falling edge after bit 0 to the next falling edge.
- `wr_strobe` fires 1 clk after the SCL rising edge that samples bit 0 of a data byte. The register updates in the same cycle, and `regs_flat` is visible the next cycle.
- `busy` rises 1 clk after ADDR_ACK is entered. It falls 1 clk after STOP is detected.

## Configuration
- `I2C_TARGET_FILTER_EN` defined: a FILT_LEN-cycle majority/stability filter sits on SCL and SDA after the synchronizer. A level changes only after FILT_LEN consecutive equal samples, so pulses shorter than FILT_LEN clk are rejected.
- Not defined: synchronizer only. FILT_LEN is ignored and input latency is 2 clk.

## Structure
- Package `i2c_target_pkg` holds:
  - the state enum;
  - the ACK/NACK bit constants;
  - the R/W bit position constant.
- Sub-module `i2c_bus_sampler` contains the synchronizer, the macro-guarded filter, and the SCL rise/fall and START/STOP detectors. Its outputs are `scl_rise`, `scl_fall`, `start_det`, `stop_det` and `sda_s`.
- Top level contains the FSM, shift register, pointer and register file.

## Test plan
- Write 0x2A+W, ptr 0x03, data 0x11 0x22 → every byte ACKed; reg3=0x11, reg4=0x22; two `wr_strobe` pulses with addr 3 and 4.
- Write ptr 0x0F, data 0xAA 0xBB (NUM_REGS=16) → reg15=0xAA, reg0=0xBB (wrap).
- Write ptr 0x05, repeated START, 0x2A+R, read 3 bytes with ACK, ACK, NACK, STOP → returns reg5, reg6, reg7; SDA released after the NACK; `busy` drops after STOP.
- Address 0x2B → NACK; no `wr_strobe` for the whole transaction; `sda_oe` stays 0.
- Same-cycle `hw_we` to reg4 with 0x55 and I2C write to reg4 of 0x66 → reg4=0x66. `hw_we` to reg2 during a read of reg2 → the byte on the bus keeps its old value.
- Assert `rst_n` low during ADDR_ACK → `sda_oe=0` immediately; after release, all registers are 0 and a fresh transaction works. With the filter macro, a 2-clk SDA low glitch while SCL is high produces no START.
